// File: rtl/lx32_isa_pkg.sv
// rtl/lx32_isa_pkg.sv - RV32I opcode set, encoder request struct and immediate range limits
package lx32_isa_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F
  } opcode_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_enc_comb.sv
// rtl/instr_enc_comb.sv - combinational RV32I field packer: enc_req_t -> {instr, err}
// Optional immediate range/alignment flagging enabled by LX32_IMM_RANGE_CHK_EN.
module instr_enc_comb
  import lx32_isa_pkg::*;
(
  input  enc_req_t    req_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic        undef_op;
  logic [31:0] imm;

  assign imm = req_i.imm;

  always_comb begin
    instr_o  = INSTR_NOP;
    undef_op = 1'b0;
    case (req_i.opcode)
      OP_OP:
        instr_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      OP_IMM, OP_LOAD, OP_JALR:
        instr_o = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      OP_STORE:
        instr_o = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm[4:0], req_i.opcode};
      OP_BRANCH:
        instr_o = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                   imm[4:1], imm[11], req_i.opcode};
      OP_LUI, OP_AUIPC:
        instr_o = {imm[31:12], req_i.rd, req_i.opcode};
      OP_JAL:
        instr_o = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, req_i.opcode};
      default: begin
        instr_o  = INSTR_NOP;
        undef_op = 1'b1;
      end
    endcase
  end

`ifdef LX32_IMM_RANGE_CHK_EN
  logic range_err;

  // Word is still emitted with truncated fields; only the flag reports the loss.
  always_comb begin
    range_err = 1'b0;
    case (req_i.opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE:
        range_err = !imm_in_range(imm, IMM_I_MIN, IMM_I_MAX);
      OP_BRANCH:
        range_err = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      OP_JAL:
        range_err = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      OP_LUI, OP_AUIPC:
        range_err = |imm[11:0];
      default:
        range_err = 1'b0;
    endcase
  end

  assign err_o = undef_op | range_err;
`else
  assign err_o = undef_op;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I instruction encoder with 2-entry output buffer
// Range checking follows LX32_IMM_RANGE_CHK_EN inside instr_enc_comb.
module instr_encoder
  import lx32_isa_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  enc_req_t    req;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        push;
  logic        pop;

  buf_state_t           state_q, state_d;
  logic [31:0]          head_instr_q, head_instr_d;
  logic                 head_err_q, head_err_d;
  logic [31:0]          tail_instr_q, tail_instr_d;
  logic                 tail_err_q, tail_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign req = '{
    opcode: opcode_t'(in_opcode),
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    funct3: in_funct3,
    funct7: in_funct7,
    imm:    in_imm
  };

  instr_enc_comb u_enc (
    .req_i   (req),
    .instr_o (enc_instr),
    .err_o   (enc_err)
  );

  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_instr = head_instr_q;
  assign out_err   = head_err_q;
  assign err_cnt   = err_cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head slot always drives the outputs; tail only holds the second entry while FULL.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_err_d   = head_err_q;
    tail_instr_d = tail_instr_q;
    tail_err_d   = tail_err_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
          state_d      = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_instr_d = enc_instr;
          head_err_d   = enc_err;
        end else if (push) begin
          tail_instr_d = enc_instr;
          tail_err_d   = enc_err;
          state_d      = BUF_FULL;
        end else if (pop) begin
          state_d      = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          head_instr_d = tail_instr_q;
          head_err_d   = tail_err_q;
          state_d      = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      head_instr_q <= '0;
      head_err_q   <= 1'b0;
      tail_instr_q <= '0;
      tail_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_err_q   <= head_err_d;
      tail_instr_q <= tail_instr_d;
      tail_err_q   <= tail_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a FIFO reference model
module tb_instr_encoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic          out_err;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  int          exp_cnt;
  logic        last_accept;
  int          pops;

  always #5 clk = ~clk;

  instr_encoder #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bitv(input logic [31:0] v, input int n);
    return (v >> n) & 32'd1;
  endfunction

  // Reference: returns {err, instr} built from field placement rules with shifts and masks.
  function automatic logic [32:0] model(input logic [6:0] op7, input logic [4:0] rd5,
                                        input logic [4:0] rs15, input logic [4:0] rs25,
                                        input logic [2:0] f33, input logic [6:0] f77,
                                        input logic [31:0] imm);
    logic [31:0] op, rd, rs1, rs2, f3, f7, w;
    logic        rerr, uerr;
    int          s;
    op = 32'(op7); rd = 32'(rd5); rs1 = 32'(rs15); rs2 = 32'(rs25);
    f3 = 32'(f33); f7 = 32'(f77);
    s = $signed(imm);
    rerr = 1'b0; uerr = 1'b0;
    case (op7)
      7'h33: w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      7'h13, 7'h03, 7'h67: begin
        w = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        rerr = (s < -2048) || (s > 2047);
      end
      7'h23: begin
        w = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((imm & 32'h1F) << 7) | op;
        rerr = (s < -2048) || (s > 2047);
      end
      7'h63: begin
        w = (bitv(imm, 12) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
            | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) | (bitv(imm, 11) << 7) | op;
        rerr = (s < -4096) || (s > 4094) || (imm[0] != 1'b0);
      end
      7'h37, 7'h17: begin
        w = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        rerr = (imm & 32'hFFF) != 0;
      end
      7'h6F: begin
        w = (bitv(imm, 20) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (bitv(imm, 11) << 20)
            | (imm & 32'h000F_F000) | (rd << 7) | op;
        rerr = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (imm[0] != 1'b0);
      end
      default: begin
        w = 32'h13;
        uerr = 1'b1;
      end
    endcase
`ifdef LX32_IMM_RANGE_CHK_EN
    return {uerr | rerr, w};
`else
    if (rerr) rerr = 1'b0;
    return {uerr, w};
`endif
  endfunction

  // One clock: check DUT against the model at the falling edge, then advance the model.
  task automatic step();
    logic [32:0] e;
    logic        acc, pp;
    @(negedge clk);
    chk("in_ready", in_ready, exp_q.size() < 2);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("err_cnt", err_cnt, exp_cnt);
    if (exp_q.size() != 0 && out_valid) begin
      chk("out_instr", out_instr, exp_q[0][31:0]);
      chk("out_err", out_err, exp_q[0][32]);
    end
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      pops++;
    end
    if (acc) begin
      e = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
      exp_q.push_back(e);
      if (e[32] && exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    last_accept = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic directed(input string tag, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [31:0] imm, input logic [31:0] ei, input logic ee);
    drive(op, rd, rs1, rs2, f3, 7'h0, imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    #3;
    chk({tag, "_lat"}, out_valid, 1'b1);
    chk({tag, "_instr"}, out_instr, ei);
    chk({tag, "_err"}, out_err, ee);
    step();
  endtask

  logic [31:0] edge_imm [12] = '{32'hFFFF_F7FF, 32'hFFFF_F800, 32'd2047, 32'd2048,
                                 32'hFFFF_EFFF, 32'hFFFF_F000, 32'd4094, 32'd4095,
                                 32'hFFF0_0000, 32'h000F_FFFE, 32'h0010_0000, 32'h0001_2000};
  logic [6:0]  ops [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

  task automatic rand_req();
    logic [31:0] imm;
    logic [6:0]  op;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2: imm = edge_imm[$urandom_range(0, 11)];
      default: imm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
    endcase
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    drive(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
  endtask

  initial begin
    exp_cnt = 0; pops = 0; last_accept = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    directed("addi", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    directed("sw",   7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8,         32'h0020_A423, 1'b0);
    directed("beq",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    directed("jal",  7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800,       32'h0010_00EF, 1'b0);
    directed("undef", 7'h7F, 5'd3, 5'd4, 5'd5, 3'd1, 32'h1234,     32'h0000_0013, 1'b1);
    chk("undef_cnt", err_cnt, 1);
`ifdef LX32_IMM_RANGE_CHK_EN
    directed("addi2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b1);
`else
    directed("addi2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b0);
`endif

    // Backpressure: three requests against a stalled consumer, then release.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0 || last_accept) drive(7'h13, 5'(i + 1), 5'd2, 5'd0, 3'd0, 7'h0, 32'(i + 7));
      in_valid = 1'b1;
      step();
    end
    #3;
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    chk("bp_head", out_instr, 32'h0071_0093);
    out_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_accept) break;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("bp_words", pops, 3);

    // Saturation of the narrow error counter.
    in_valid = 1'b1;
    drive(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    for (int k = 0; k < 20; k++) step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("err_sat", err_cnt, (1 << CW) - 1);

    // Reset while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'h0, 32'hABCD_E000);
    step();
    step();
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", out_valid, 1'b0);
    chk("rstmid_in_ready", in_ready, 1'b1);
    chk("rstmid_err_cnt", err_cnt, 0);
    chk("rstmid_out_instr", out_instr, 32'h0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      rand_req();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
